hit_merge: RTL

HIT_MERGE -- requirements
Module: hit_merge

---
 rtl/hit_merge_pkg.sv | 20 ++
 rtl/hit_fifo.sv | 67 ++++++
 rtl/hit_merge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hit_merge_pkg.sv
// Shared types and default sizes for the hit merge path.
// frag_t is one serialized fragment: signed x/y/z position words followed by
// unsigned color words, each SIGFIG_DEF bits wide (hit occupies the upper bits).
package hit_merge_pkg;

    localparam int unsigned SIGFIG_DEF = 24;
    localparam int unsigned RADIX_DEF  = 10;
    localparam int unsigned AXIS_DEF   = 3;
    localparam int unsigned COLORS_DEF = 3;
    localparam int unsigned LANES_DEF  = 4;
    localparam int unsigned DEPTH_DEF  = 8;

    typedef struct packed {
        logic signed [AXIS_DEF-1:0][SIGFIG_DEF-1:0] hit;
        logic        [COLORS_DEF-1:0][SIGFIG_DEF-1:0] color;
    } frag_t;

    localparam int unsigned FRAG_W_DEF = $bits(frag_t);

endpackage : hit_merge_pkg

// File: rtl/hit_fifo.sv
// Fragment buffer: circular storage with up to LANES writes and one read per cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (clears pointers/occupancy only)
//   push_data_i       compacted write slots; slot k is written when k < push_cnt_i
//   push_cnt_i        number of slots to write this cycle (0..LANES)
//   pop_i             retire the oldest entry (ignored while empty)
//   rd_data_o         oldest entry, valid whenever count_o != 0
//   count_o           registered occupancy, log2(DEPTH)+1 bits
module hit_fifo
    import hit_merge_pkg::*;
#(
    parameter int unsigned W     = FRAG_W_DEF,
    parameter int unsigned LANES = LANES_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [LANES-1:0][W-1:0]            push_data_i,
    input  logic [$clog2(LANES+1)-1:0]         push_cnt_i,
    input  logic                               pop_i,
    output logic [W-1:0]                       rd_data_o,
    output logic [$clog2(DEPTH):0]             count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned LW = $clog2(LANES + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok_c;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        pop_ok_c = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok_c);
        count_d  = count_q + CW'(push_cnt_i) - CW'(pop_ok_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (LW'(k) < push_cnt_i) begin
                mem_q[wr_ptr_q + PW'(k)] <= push_data_i[k];
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

endmodule : hit_fifo

// File: rtl/hit_merge.sv
// Merges up to LANES parallel hits per cycle into a single fragment stream.
// Valid lanes of an accepted R18 bundle are compacted (lane 0 first) into the
// fragment buffer; the oldest fragment is offered on R19 to the z-buffer.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   hit_R18S            per-lane signed x,y,z words
//   color_R18U          per-lane unsigned color words
//   hit_valid_R18H      per-lane valid
//   halt_RnnnnL         high = R18 bundle accepted on this edge (from occupancy only)
//   hit_R19S/color_R19U oldest buffered fragment
//   hit_valid_R19H      buffer non-empty
//   zb_ready_R19H       z-buffer takes the fragment this cycle
//   frag_count_U        fragments delivered since reset, wraps at 2^32
module hit_merge
    import hit_merge_pkg::*;
#(
    parameter int unsigned SIGFIG = SIGFIG_DEF,
    parameter int unsigned RADIX  = RADIX_DEF,
    parameter int unsigned AXIS   = AXIS_DEF,
    parameter int unsigned COLORS = COLORS_DEF,
    parameter int unsigned LANES  = LANES_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic signed [LANES-1:0][AXIS-1:0][SIGFIG-1:0]   hit_R18S,
    input  logic        [LANES-1:0][COLORS-1:0][SIGFIG-1:0] color_R18U,
    input  logic        [LANES-1:0]                     hit_valid_R18H,
    output logic                                        halt_RnnnnL,
    output logic signed [AXIS-1:0][SIGFIG-1:0]          hit_R19S,
    output logic        [COLORS-1:0][SIGFIG-1:0]        color_R19U,
    output logic                                        hit_valid_R19H,
    input  logic                                        zb_ready_R19H,
    output logic [31:0]                                 frag_count_U
);

    localparam int unsigned HIT_W  = AXIS * SIGFIG;
    localparam int unsigned COL_W  = COLORS * SIGFIG;
    localparam int unsigned FRAG_W = HIT_W + COL_W;
    localparam int unsigned LW     = $clog2(LANES + 1);
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    // Position words are passed through untouched, so RADIX only has to be sane.
    if (RADIX >= SIGFIG) begin : g_bad_radix
        $error("hit_merge: RADIX must be smaller than SIGFIG");
    end
    if ((DEPTH < 2 * LANES) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hit_merge: DEPTH must be a power of two and at least 2*LANES");
    end

    logic [LANES-1:0][FRAG_W-1:0] lane_frag_c;
    logic [LANES-1:0][FRAG_W-1:0] slot_c;
    logic [LANES-1:0][LW-1:0]     pos_c;
    logic [LW-1:0]                valid_cnt_c;
    logic [LW-1:0]                push_cnt_c;
    logic                         pop_c;
    logic [FRAG_W-1:0]            rd_frag;
    logic [CW-1:0]                occ;
    logic [31:0]                  frag_count_q, frag_count_d;

    // Flatten each lane into fragment layout: hit in the upper bits, color below.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_frag_c[l] = {hit_R18S[l], color_R18U[l]};
        end
    end

    // Prefix count: pos_c[l] is the number of valid lanes below lane l.
    always_comb begin : prefix_count
        logic [LW-1:0] run;
        run   = '0;
        pos_c = '0;
        for (int l = 0; l < LANES; l++) begin
            pos_c[l] = run;
            run      = run + LW'(hit_valid_R18H[l]);
        end
        valid_cnt_c = run;
    end

    // Route each valid lane to the slot named by its prefix count.
    always_comb begin
        slot_c = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int l = 0; l < LANES; l++) begin
                if (hit_valid_R18H[l] && (pos_c[l] == LW'(k))) begin
                    slot_c[k] = lane_frag_c[l];
                end
            end
        end
    end

    // Headroom for a full bundle is what gates acceptance.
    assign halt_RnnnnL    = (occ <= CW'(DEPTH - LANES));
    assign hit_valid_R19H = (occ != '0);
    assign push_cnt_c     = halt_RnnnnL ? valid_cnt_c : '0;
    assign pop_c          = hit_valid_R19H && zb_ready_R19H;

    hit_fifo #(
        .W     (FRAG_W),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .push_data_i (slot_c),
        .push_cnt_i  (push_cnt_c),
        .pop_i       (pop_c),
        .rd_data_o   (rd_frag),
        .count_o     (occ)
    );

    assign hit_R19S   = rd_frag[FRAG_W-1:COL_W];
    assign color_R19U = rd_frag[COL_W-1:0];

    // Delivered-fragment counter.
    always_comb begin
        frag_count_d = frag_count_q + 32'(pop_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frag_count_q <= '0;
        end else begin
            frag_count_q <= frag_count_d;
        end
    end

    assign frag_count_U = frag_count_q;

endmodule : hit_merge
